dpdm_encode: RTL and testbench

- USB transmit path of the controller: serialises one packet (SYNC, PID, optional payload bytes, EOP) onto the DP/DM pair.
- Applies bit stuffing and NRZI encoding, and drives `host_sending` for the whole packet so the receive decoder ignores our own traffic.
- Payload bytes (CRC16 included) are pulled from an upstream byte source with a valid/ready handshake.

---
 rtl/usb_pkg.sv | 28 ++
 rtl/dpdm_encode_if.sv | 22 ++
 rtl/nrzi_stuff_enc.sv | 43 ++++
 rtl/dpdm_encode.sv | 134 +++++++++++++
 tb/tb_dpdm_encode.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared constants and types for the USB transmit path.
package usb_pkg;

  localparam logic [7:0] PidAck   = 8'hD2;
  localparam logic [7:0] PidNak   = 8'h5A;
  localparam logic [7:0] PidData0 = 8'hC3;
  localparam logic [7:0] PidData1 = 8'h4B;
  localparam logic [7:0] PidIn    = 8'h69;
  localparam logic [7:0] PidOut   = 8'hE1;
  localparam logic [7:0] PidSetup = 8'h2D;

  // Sent LSB first: seven raw 0s followed by a raw 1.
  localparam logic [7:0] SyncRaw = 8'h80;

  localparam int unsigned StuffLimit = 6;

  typedef enum logic [1:0] {LineJ, LineK, LineSe0} line_t;

  typedef logic [2:0] enc_state_t;
  localparam enc_state_t StIdle = 3'd0;
  localparam enc_state_t StSync = 3'd1;
  localparam enc_state_t StPid  = 3'd2;
  localparam enc_state_t StData = 3'd3;
  localparam enc_state_t StEop0 = 3'd4;
  localparam enc_state_t StEop1 = 3'd5;
  localparam enc_state_t StEop2 = 3'd6;

endpackage

// File: rtl/dpdm_encode_if.sv
// Packet request, payload byte handshake and completion signals of the USB transmitter.
interface dpdm_encode_if;
  logic       send_start;
  logic [7:0] pid;
  logic       has_data;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       done;
  logic       underrun;

  modport master (
    output send_start, pid, has_data, byte_in, byte_valid, byte_last,
    input  byte_ready, done, underrun
  );

  modport slave (
    input  send_start, pid, has_data, byte_in, byte_valid, byte_last,
    output byte_ready, done, underrun
  );
endinterface

// File: rtl/nrzi_stuff_enc.sv
// Bit stuffer and NRZI level generator; the output level is valid for the current bit time
// and the run count and level advance on each bit tick.
module nrzi_stuff_enc
  import usb_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  raw,
  input  logic  tick,
  input  logic  enable,
  output line_t level,
  output logic  stall,
  output logic  stuff_due
);

  logic [2:0] run_q;
  line_t      level_q;
  logic       bit_out;

  // A full run of ones turns the current bit time into a stuffed zero.
  assign stall     = enable && (run_q == 3'(StuffLimit));
  assign bit_out   = stall ? 1'b0 : raw;
  assign stuff_due = enable && !stall && raw && (run_q == 3'(StuffLimit - 1));

  always_comb begin
    level = level_q;
    if (!bit_out) level = (level_q == LineJ) ? LineK : LineJ;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= LineJ;
      run_q   <= '0;
    end else if (!enable) begin
      level_q <= LineJ;
      run_q   <= '0;
    end else if (tick) begin
      level_q <= level;
      run_q   <= bit_out ? run_q + 3'd1 : 3'd0;
    end
  end

endmodule

// File: rtl/dpdm_encode.sv
// USB packet transmitter: SYNC, PID, optional payload and EOP serialised onto DP/DM with
// bit stuffing and NRZI; payload bytes are pulled through a valid/ready handshake.
module dpdm_encode
  import usb_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic          clock,
  input  logic          reset,
  dpdm_encode_if.slave  bus,
  output logic          DP_out,
  output logic          DM_out,
  output logic          host_sending
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  enc_state_t    state_q, state_d;
  logic [CW-1:0] cyc_q;
  logic [7:0]    shift_q, shift_d, pid_q;
  logic [2:0]    bit_q, bit_d;
  logic          has_data_q, last_q, last_d, tail_q, tail_d, done_q;
  logic          tick, stall, stuff_due, enc_en, bit_end, field_end;
  logic          ready, underrun;
  line_t         level, line;

  assign tick    = (cyc_q == CW'(BIT_CYCLES - 1));
  assign enc_en  = (state_q == StSync) || (state_q == StPid) || (state_q == StData);
  assign bit_end = tick && !stall;
  // A field ends on its eighth bit, or after the stuff bit owed by that eighth bit.
  assign field_end = tick && ((stall && tail_q) || (!stall && bit_q == 3'd7 && !stuff_due));

  nrzi_stuff_enc u_enc (
    .clock     (clock),
    .reset     (reset),
    .raw       (shift_q[0]),
    .tick      (tick),
    .enable    (enc_en),
    .level     (level),
    .stall     (stall),
    .stuff_due (stuff_due)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    last_d   = last_q;
    tail_d   = tail_q;
    ready    = 1'b0;
    underrun = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.send_start) begin
          state_d = StSync;
          shift_d = SyncRaw;
          bit_d   = '0;
          last_d  = 1'b0;
          tail_d  = 1'b0;
        end
      end
      StSync, StPid, StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7 && stuff_due) tail_d = 1'b1;
        end
        if (field_end) begin
          tail_d = 1'b0;
          bit_d  = '0;
          if (state_q == StSync) begin
            state_d = StPid;
            shift_d = pid_q;
          end else if ((state_q == StPid && !has_data_q) || (state_q == StData && last_q)) begin
            state_d = StEop0;
          end else if (bus.byte_valid) begin
            ready   = 1'b1;
            shift_d = bus.byte_in;
            last_d  = bus.byte_last;
            state_d = StData;
          end else begin
            underrun = 1'b1;
            state_d  = StEop0;
          end
        end
      end
      StEop0:  if (tick) state_d = StEop1;
      StEop1:  if (tick) state_d = StEop2;
      StEop2:  if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      shift_q    <= '0;
      pid_q      <= '0;
      bit_q      <= '0;
      has_data_q <= 1'b0;
      last_q     <= 1'b0;
      tail_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      tail_q  <= tail_d;
      done_q  <= (state_q == StEop2) && tick;
      if (state_q == StIdle || tick) cyc_q <= '0;
      else                           cyc_q <= cyc_q + CW'(1);
      if (state_q == StIdle && bus.send_start) begin
        pid_q      <= bus.pid;
        has_data_q <= bus.has_data;
      end
    end
  end

  always_comb begin
    line = level;
    if (state_q == StEop0 || state_q == StEop1) line = LineSe0;
    else if (state_q == StEop2)                 line = LineJ;
  end

  assign host_sending   = (state_q != StIdle);
  assign DP_out         = host_sending ? (line == LineJ) : 1'bz;
  assign DM_out         = host_sending ? (line == LineK) : 1'bz;
  assign bus.byte_ready = ready;
  assign bus.underrun   = underrun;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_dpdm_encode.sv
// Scoreboard bench for dpdm_encode: two instances (1 and 4 cycles per bit) checked against
// a bit-list model of SYNC/PID/payload, stuffing, NRZI and EOP.
module tb_dpdm_encode;
  import usb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dpdm_encode_if bus1 ();
  dpdm_encode_if bus4 ();
  wire  dp1, dm1, dp4, dm4;
  logic hs1, hs4;

  dpdm_encode #(.BIT_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave),
    .DP_out(dp1), .DM_out(dm1), .host_sending(hs1)
  );
  dpdm_encode #(.BIT_CYCLES(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4.slave),
    .DP_out(dp4), .DM_out(dm4), .host_sending(hs4)
  );

  logic       sel = 1'b0;
  logic       send_start = 1'b0;
  logic [7:0] pid = 8'h00;
  logic       has_data = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_last = 1'b0;

  assign bus1.send_start = send_start && !sel;
  assign bus4.send_start = send_start && sel;
  assign bus1.pid = pid;            assign bus4.pid = pid;
  assign bus1.has_data = has_data;  assign bus4.has_data = has_data;
  assign bus1.byte_in = byte_in;    assign bus4.byte_in = byte_in;
  assign bus1.byte_valid = byte_valid; assign bus4.byte_valid = byte_valid;
  assign bus1.byte_last = byte_last;   assign bus4.byte_last = byte_last;

  logic rdy, unr, dn, hs, dp, dm;
  assign rdy = sel ? bus4.byte_ready : bus1.byte_ready;
  assign unr = sel ? bus4.underrun   : bus1.underrun;
  assign dn  = sel ? bus4.done       : bus1.done;
  assign hs  = sel ? hs4 : hs1;
  assign dp  = sel ? dp4 : dp1;
  assign dm  = sel ? dm4 : dm1;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int exp_rdy = 0;
  int exp_unr = 0;
  logic [7:0] pay [8];
  int npay = 0;
  int nsup = 0;
  int bidx = 0;
  logic [7:0] pids [7] = '{PidAck, PidNak, PidData0, PidData1, PidIn, PidOut, PidSetup};

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected line symbols per clock: 0=J, 1=K, 2=SE0.
  function automatic void push_expect(input logic [7:0] p, input bit hd, input int bcs);
    bit raw[$];
    bit st[$];
    int run = 0;
    int lvl = 0;
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    for (int i = 0; i < 8; i++) raw.push_back(p[i]);
    if (hd) for (int b = 0; b < nsup; b++) for (int i = 0; i < 8; i++) raw.push_back(pay[b][i]);
    foreach (raw[i]) begin
      st.push_back(raw[i]);
      run = raw[i] ? run + 1 : 0;
      if (run == 6) begin
        st.push_back(1'b0);
        run = 0;
      end
    end
    foreach (st[i]) begin
      if (!st[i]) lvl = 1 - lvl;
      for (int c = 0; c < bcs; c++) exp_q.push_back(lvl);
    end
    for (int c = 0; c < 2 * bcs; c++) exp_q.push_back(2);
    for (int c = 0; c < bcs; c++) exp_q.push_back(0);
    exp_rdy = hd ? nsup : 0;
    exp_unr = (hd && nsup < npay) ? 1 : 0;
  endfunction

  function automatic void drive_bytes();
    byte_valid = has_data && (bidx < nsup);
    byte_in    = pay[bidx % 8];
    byte_last  = (bidx == npay - 1) && (nsup == npay);
  endfunction

  task automatic start_pkt(input bit s, input logic [7:0] p, input bit hd, input int n,
                           input int u);
    sel = s;
    npay = n;
    nsup = u;
    bidx = 0;
    pid = p;
    has_data = hd;
    drive_bytes();
    send_start = 1'b1;
    @(posedge clock);
    #1;
    send_start = 1'b0;
    push_expect(p, hd, s ? 4 : 1);
  endtask

  // Serve the byte source until done is seen (returns at that negedge).
  task automatic serve(input int glitch_at);
    bit got = 1'b0;
    bit take;
    int cyc = 0;
    while (!got && cyc < 3000) begin
      send_start = (cyc == glitch_at);
      drive_bytes();
      @(negedge clock);
      if (dn) begin
        got = 1'b1;
        send_start = 1'b0;
      end else begin
        take = rdy;
        @(posedge clock);
        #1;
        if (take) bidx++;
        cyc++;
      end
    end
    if (!got) check("done_timeout", dn, 1);
  endtask

  // Monitor: pops one expected symbol per clock while the DUT drives the lines.
  initial begin
    bit want_done = 1'b0;
    int nrdy = 0;
    int nunr = 0;
    int sym;
    forever begin
      @(negedge clock);
      if (reset) begin
        want_done = 1'b0;
        nrdy = 0;
        nunr = 0;
      end else begin
        if (rdy) nrdy++;
        if (unr) nunr++;
        if (want_done) begin
          check("done_pulse", dn, 1);
          check("hs_release", hs, 0);
          check("ready_count", nrdy, exp_rdy);
          check("underrun_count", nunr, exp_unr);
          want_done = 1'b0;
          nrdy = 0;
          nunr = 0;
        end else begin
          check("done_idle", dn, 0);
        end
        if (hs) begin
          if (exp_q.size() == 0) begin
            check("extra_hs", hs, 0);
          end else begin
            sym = (dp && !dm) ? 0 : (!dp && dm) ? 1 : (!dp && !dm) ? 2 : 3;
            check("line", sym, exp_q.pop_front());
            if (exp_q.size() == 0) want_done = 1'b1;
          end
        end else if (exp_q.size() > 0 && !dn) begin
          check("hs_missing", hs, 1);
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    int n, u;
    repeat (2) @(posedge clock);
    #1;
    check("rst_hs1", hs1, 0);
    check("rst_hs4", hs4, 0);
    check("rst_done", bus1.done, 0);
    check("rst_unr", bus1.underrun, 0);
    reset = 1'b0;
    byte_valid = 1'b1;
    @(posedge clock);
    #1;
    check("idle_ready", rdy, 0);
    check("idle_hs", hs, 0);
    byte_valid = 1'b0;

    // ACK, one cycle per bit.
    start_pkt(1'b0, PidAck, 1'b0, 0, 0);
    serve(-1);
    // DATA0 with stuffing inside the first payload byte.
    pay[0] = 8'hFF; pay[1] = 8'h00;
    start_pkt(1'b0, PidData0, 1'b1, 2, 2);
    serve(-1);
    // Underrun right after the PID.
    start_pkt(1'b0, PidData0, 1'b1, 2, 0);
    serve(-1);
    // Stuff bit owed after the final payload bit.
    pay[0] = 8'hFC;
    start_pkt(1'b0, PidData1, 1'b1, 1, 1);
    serve(-1);
    // NAK, four cycles per bit.
    start_pkt(1'b1, PidNak, 1'b0, 0, 0);
    serve(-1);

    // Reset mid-PID aborts at once.
    start_pkt(1'b0, PidAck, 1'b0, 0, 0);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("abort_hs", hs1, 0);
    check("abort_done", bus1.done, 0);
    check("abort_ready", bus1.byte_ready, 0);
    check("abort_unr", bus1.underrun, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    start_pkt(1'b0, PidAck, 1'b0, 0, 0);
    serve(-1);

    // Ignored start during DATA, then back-to-back start in the done cycle.
    pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'h56;
    start_pkt(1'b0, PidData1, 1'b1, 3, 3);
    serve(25);
    start_pkt(1'b0, PidAck, 1'b0, 0, 0);
    serve(-1);

    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(1, 4);
      u = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : n;
      for (int b = 0; b < 8; b++) pay[b] = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
      @(posedge clock);
      #1;
      start_pkt(1'($urandom_range(0, 1)), pids[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                n, u);
      serve(-1);
    end

    @(posedge clock);
    @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
